// File: rtl/axi_dmem_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_dmem_slave_if
// Purpose  : AXI4 burst bus bundle (AW/W/B/AR/R) for the data-memory slave.
// Revision : 1.0
// ============================================================================
interface axi_dmem_slave_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic [7:0]                    S_AXI_AWLEN;
  logic                          S_AXI_AWVALID;
  logic                          S_AXI_AWREADY;
  logic [31:0]                   S_AXI_WDATA;
  logic [3:0]                    S_AXI_WSTRB;
  logic                          S_AXI_WLAST;
  logic                          S_AXI_WVALID;
  logic                          S_AXI_WREADY;
  logic [1:0]                    S_AXI_BRESP;
  logic                          S_AXI_BVALID;
  logic                          S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic [7:0]                    S_AXI_ARLEN;
  logic                          S_AXI_ARVALID;
  logic                          S_AXI_ARREADY;
  logic [31:0]                   S_AXI_RDATA;
  logic [1:0]                    S_AXI_RRESP;
  logic                          S_AXI_RLAST;
  logic                          S_AXI_RVALID;
  logic                          S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface
`default_nettype wire

// File: rtl/axi_dmem_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_dmem_slave
// Purpose  : AXI4 INCR-burst slave over a C_MEM_DEPTH x 32-bit memory with
//            independent read/write FSMs. Define AXI_DMEM_SLAVE_RANGECHK_EN to
//            return SLVERR for bursts starting beyond the memory.
// Revision : 1.0
// ============================================================================
module axi_dmem_slave #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_MEM_DEPTH        = 1024
) (
  input wire              CLK,
  input wire              RST,
  axi_dmem_slave_if.slave s_axi
);

  localparam int IDX_W = $clog2(C_MEM_DEPTH);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } rstate_t;

  logic [31:0] mem [C_MEM_DEPTH];

  wstate_t     wstate;
  idx_t        waddr;
  logic [7:0]  wcount;
  logic        werr;
  logic        awready;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;

  rstate_t     rstate;
  idx_t        raddr;
  logic [7:0]  rcount;
  logic        rerr;
  logic        arready;
  logic        rvalid;
  logic        rlast;
  logic [1:0]  rresp;
  logic [31:0] rdata;

  logic        aw_oob;
  logic        ar_oob;
  logic        mem_we;
  logic        unused;

  // Only the start address is range-checked; the burst then wraps in memory.
`ifdef AXI_DMEM_SLAVE_RANGECHK_EN
  localparam logic [C_S_AXI_ADDR_WIDTH:0] MEM_BYTES =
    (C_S_AXI_ADDR_WIDTH+1)'(4 * C_MEM_DEPTH);
  assign aw_oob = ({1'b0, s_axi.S_AXI_AWADDR} >= MEM_BYTES);
  assign ar_oob = ({1'b0, s_axi.S_AXI_ARADDR} >= MEM_BYTES);
`else
  assign aw_oob = 1'b0;
  assign ar_oob = 1'b0;
`endif

  assign unused = ^{s_axi.S_AXI_WLAST, s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = bresp;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RLAST   = rlast;
  assign s_axi.S_AXI_RRESP   = rresp;
  assign s_axi.S_AXI_RDATA   = rdata;

  assign mem_we = (wstate == W_DATA) && wready && s_axi.S_AXI_WVALID && !werr;

  // Memory is deliberately outside the reset domain so contents survive RST.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi.S_AXI_WSTRB[b]) begin
          mem[waddr][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wstate  <= W_IDLE;
      waddr   <= '0;
      wcount  <= '0;
      werr    <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
    end else begin
      case (wstate)
        W_IDLE: begin
          awready <= 1'b1;
          if (s_axi.S_AXI_AWVALID && awready) begin
            waddr   <= s_axi.S_AXI_AWADDR[IDX_W+1:2];
            wcount  <= s_axi.S_AXI_AWLEN;
            werr    <= aw_oob;
            awready <= 1'b0;
            wready  <= 1'b1;
            wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi.S_AXI_WVALID) begin
            waddr  <= waddr + idx_t'(1);
            wcount <= wcount - 8'd1;
            if (wcount == 8'd0) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bresp  <= werr ? 2'b10 : 2'b00;
              wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Memory is sampled with the pre-edge contents, so a same-edge write is not
  // visible to the fetch (read-first).
  always_ff @(posedge CLK) begin
    if (RST) begin
      rstate  <= R_IDLE;
      raddr   <= '0;
      rcount  <= '0;
      rerr    <= 1'b0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= 2'b00;
      rdata   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          arready <= 1'b1;
          if (s_axi.S_AXI_ARVALID && arready) begin
            raddr   <= s_axi.S_AXI_ARADDR[IDX_W+1:2];
            rcount  <= s_axi.S_AXI_ARLEN;
            rerr    <= ar_oob;
            arready <= 1'b0;
            rstate  <= R_FETCH;
          end
        end
        R_FETCH: begin
          rdata  <= rerr ? 32'd0 : mem[raddr];
          rresp  <= rerr ? 2'b10 : 2'b00;
          rlast  <= (rcount == 8'd0);
          rvalid <= 1'b1;
          rstate <= R_DATA;
        end
        R_DATA: begin
          if (s_axi.S_AXI_RREADY) begin
            rvalid <= 1'b0;
            if (rlast) begin
              rlast   <= 1'b0;
              arready <= 1'b1;
              rstate  <= R_IDLE;
            end else begin
              raddr  <= raddr + idx_t'(1);
              rcount <= rcount - 8'd1;
              rstate <= R_FETCH;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
